val2_shift_pipe: RTL and testbench

VAL2_SHIFT_PIPE -- requirements
Module: val2_shift_pipe

---
 rtl/val2_shift_pipe.sv | 186 ++++++++++++++++++
 tb/tb_val2_shift_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/val2_shift_pipe.sv
// val2_shift_pipe: two-stage operand-2 shifter for data-processing and
// load/store offsets, with valid/ready handshakes on both sides.
module val2_shift_pipe #(
    parameter int DATA_W         = 32,
    parameter int MEM_OFF_SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [7:0]        val_rs,
    input  logic [11:0]       shift_operand,
    input  logic              immediate,
    input  logic              is_mem_command,
    input  logic              carry_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] val2_out,
    output logic              carry_out
);

    localparam int AW = $clog2(DATA_W);
    localparam logic [7:0] W_AMT = 8'(DATA_W);

    typedef enum logic [2:0] {
        OP_PASS,
        OP_LSL,
        OP_LSR,
        OP_ASR,
        OP_ROR,
        OP_RRX,
        OP_IMM
    } op_e;

    typedef struct packed {
        op_e               op;
        logic [7:0]        amt;
        logic [DATA_W-1:0] opnd;
        logic              cin;
        logic              rot_nz;
    } s1_t;

    s1_t               dec;
    s1_t               s1_q;
    logic              s1_valid;
    logic              s2_valid;
    logic              s2_adv;
    logic              s1_load;

    logic [DATA_W-1:0] mem_off;
    logic [4:0]        sh_amt;
    logic [1:0]        sh_type;
    logic [7:0]        eff_amt;

    logic [DATA_W:0]        lsl_w;
    logic [DATA_W:0]        lsr_w;
    logic signed [DATA_W:0] asr_w;
    logic [AW-1:0]          rot;
    logic [AW:0]            rot_c;
    logic [DATA_W-1:0]      ror_v;
    logic [DATA_W-1:0]      res_v;
    logic                   res_c;

    assign s2_adv    = !s2_valid || out_ready;
    assign in_ready  = !rst && !flush && (!s1_valid || s2_adv);
    assign s1_load   = in_valid && in_ready;
    assign out_valid = s2_valid;

    assign mem_off = (MEM_OFF_SIGNED != 0)
                   ? {{(DATA_W-12){shift_operand[11]}}, shift_operand}
                   : {{(DATA_W-12){1'b0}}, shift_operand};

    assign sh_amt  = shift_operand[11:7];
    assign sh_type = shift_operand[6:5];
    assign eff_amt = shift_operand[4] ? val_rs : {3'b000, sh_amt};

    // Decode the operation class and effective amount; memory offsets win
    // over the I bit so a load/store offset is never rotated.
    always_comb begin
        dec      = '0;
        dec.op   = OP_PASS;
        dec.opnd = val_rm;
        dec.cin  = carry_in;
        unique case (1'b1)
            is_mem_command: begin
                dec.opnd = mem_off;
            end
            (!is_mem_command && immediate): begin
                dec.op     = OP_IMM;
                dec.opnd   = {{(DATA_W-8){1'b0}}, shift_operand[7:0]};
                dec.amt    = {3'b000, shift_operand[11:8], 1'b0}
                           & (W_AMT - 8'd1);
                dec.rot_nz = |shift_operand[11:8];
            end
            default: begin
                dec.amt = eff_amt;
                unique case (sh_type)
                    2'b00:   dec.op = OP_LSL;
                    2'b01:   dec.op = OP_LSR;
                    2'b10:   dec.op = OP_ASR;
                    default: dec.op = OP_ROR;
                endcase
                if (eff_amt == 8'd0) begin
                    if (shift_operand[4] || sh_type == 2'b00) begin
                        dec.op = OP_PASS;
                    end else if (sh_type == 2'b11) begin
                        dec.op = OP_RRX;
                    end else begin
                        dec.amt = W_AMT;
                    end
                end
            end
        endcase
    end

    // Stage 1 operand/mode register, loaded on an accepted transfer.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_q <= dec;
        end
    end

    assign lsl_w = {1'b0, s1_q.opnd} << s1_q.amt;
    assign lsr_w = {s1_q.opnd, 1'b0} >> s1_q.amt;
    assign asr_w = $signed({s1_q.opnd, 1'b0}) >>> s1_q.amt;
    assign rot   = s1_q.amt[AW-1:0];
    assign rot_c = (AW+1)'(DATA_W) - {1'b0, rot};
    assign ror_v = (s1_q.opnd >> rot) | (s1_q.opnd << rot_c);

    // Barrel shift of the stage 1 operand; the extra guard bit on each
    // shift captures the last bit shifted out as the carry.
    always_comb begin
        res_v = s1_q.opnd;
        res_c = s1_q.cin;
        unique case (s1_q.op)
            OP_LSL: {res_c, res_v} = lsl_w;
            OP_LSR: {res_v, res_c} = lsr_w;
            OP_ASR: {res_v, res_c} = asr_w;
            OP_ROR: begin
                res_v = ror_v;
                res_c = ror_v[DATA_W-1];
            end
            OP_RRX: begin
                res_v = {s1_q.cin, s1_q.opnd[DATA_W-1:1]};
                res_c = s1_q.opnd[0];
            end
            OP_IMM: begin
                res_v = ror_v;
                res_c = s1_q.rot_nz ? ror_v[DATA_W-1] : s1_q.cin;
            end
            default: begin
                res_v = s1_q.opnd;
                res_c = s1_q.cin;
            end
        endcase
    end

    // Valid flags and stage 2 result; output held while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            val2_out  <= '0;
            carry_out <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    val2_out  <= res_v;
                    carry_out <= res_c;
                end
            end
            if (s1_load) begin
                s1_valid <= 1'b1;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_val2_shift_pipe.sv
// tb_val2_shift_pipe: directed and random checks of val2_shift_pipe at
// DATA_W=32 (zero-extended offsets) and DATA_W=16 (sign-extended offsets).
module tb_val2_shift_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready, imm, mem, cin;
    logic [63:0] rm;
    logic [7:0]  rs;
    logic [11:0] so;

    logic        rdy32, ov32, c32;
    logic [31:0] v32;
    logic        rdy16, ov16, c16;
    logic [15:0] v16;

    int          total = 0;
    int          bad = 0;
    logic [63:0] q32[$];
    logic [63:0] q16[$];
    bit          mon_en = 0;
    bit          stall_prev = 0;
    logic [63:0] hold32;
    logic [7:0]  rs_tbl [12] = '{8'd0, 8'd1, 8'd15, 8'd16, 8'd17, 8'd31,
                                 8'd32, 8'd33, 8'd63, 8'd64, 8'd65, 8'd255};

    val2_shift_pipe #(.DATA_W(32), .MEM_OFF_SIGNED(0)) d32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32),
        .val_rm(rm[31:0]), .val_rs(rs), .shift_operand(so),
        .immediate(imm), .is_mem_command(mem), .carry_in(cin),
        .out_valid(ov32), .out_ready(out_ready),
        .val2_out(v32), .carry_out(c32)
    );

    val2_shift_pipe #(.DATA_W(16), .MEM_OFF_SIGNED(1)) d16 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy16),
        .val_rm(rm[15:0]), .val_rs(rs), .shift_operand(so),
        .immediate(imm), .is_mem_command(mem), .carry_in(cin),
        .out_valid(ov16), .out_ready(out_ready),
        .val2_out(v16), .carry_out(c16)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rotr1(input logic [63:0] v, input int w);
        return (v >> 1) | (64'(v[0]) << (w - 1));
    endfunction

    // Bit-at-a-time reference: returns {carry, value} packed at bit w.
    function automatic logic [63:0] model(input int w, input bit sgn,
        input logic [63:0] rm_i, input logic [7:0] rs_i,
        input logic [11:0] so_i, input bit imm_i, input bit mem_i,
        input bit cin_i);
        logic [63:0] mask, v;
        bit c;
        int n, m, typ;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        v = rm_i & mask;
        c = cin_i;
        if (mem_i) begin
            v = {52'd0, so_i};
            if (sgn && so_i[11]) v = (mask & ~64'hFFF) | v;
            return (64'(c) << w) | v;
        end
        if (imm_i) begin
            v = {56'd0, so_i[7:0]};
            m = (2 * int'(so_i[11:8])) % w;
            for (int i = 0; i < m; i++) v = rotr1(v, w);
            c = (so_i[11:8] != 4'd0) ? v[w-1] : cin_i;
            return (64'(c) << w) | v;
        end
        typ = int'(so_i[6:5]);
        if (!so_i[4]) begin
            n = int'(so_i[11:7]);
            if (n == 0) begin
                if (typ == 0) return (64'(c) << w) | v;
                if (typ == 3) begin
                    c = v[0];
                    v = (v >> 1) | (64'(cin_i) << (w - 1));
                    return (64'(c) << w) | v;
                end
                n = w;
            end
        end else begin
            n = int'(rs_i);
            if (n == 0) return (64'(c) << w) | v;
        end
        case (typ)
            0: for (int i = 0; i < n; i++) begin
                c = v[w-1];
                v = (v << 1) & mask;
            end
            1: for (int i = 0; i < n; i++) begin
                c = v[0];
                v = v >> 1;
            end
            2: for (int i = 0; i < n; i++) begin
                c = v[0];
                v = (v >> 1) | (64'(v[w-1]) << (w - 1));
            end
            default: begin
                m = n % w;
                if (m == 0) c = v[w-1];
                for (int i = 0; i < m; i++) begin
                    c = v[0];
                    v = rotr1(v, w);
                end
            end
        endcase
        return (64'(c) << w) | v;
    endfunction

    // Scoreboard: queue expected results on accept, compare on drain.
    always @(negedge clk) begin
        if (mon_en) begin
            if (stall_prev) chk("hold32", {ov32, c32, v32}, hold32);
            if (in_valid && rdy32)
                q32.push_back(model(32, 0, rm, rs, so, imm, mem, cin));
            if (in_valid && rdy16)
                q16.push_back(model(16, 1, rm, rs, so, imm, mem, cin));
            if (ov32 && out_ready) begin
                if (q32.size() == 0) chk("sb32_empty", 64'(q32.size()), 1);
                else chk("sb32", {c32, v32}, q32.pop_front());
            end
            if (ov16 && out_ready) begin
                if (q16.size() == 0) chk("sb16_empty", 64'(q16.size()), 1);
                else chk("sb16", {c16, v16}, q16.pop_front());
            end
            if (rst || flush) begin
                q32.delete();
                q16.delete();
            end
            stall_prev <= ov32 && !out_ready && !rst && !flush;
            hold32 <= {1'b1, c32, v32};
        end
    end

    task automatic run_one(input string tag, input bit imm_i, input bit mem_i,
        input logic [11:0] so_i, input logic [63:0] rm_i,
        input logic [7:0] rs_i, input bit cin_i,
        input logic [63:0] e32, input logic [63:0] e16);
        @(posedge clk); #1;
        imm = imm_i; mem = mem_i; so = so_i; rm = rm_i; rs = rs_i;
        cin = cin_i; in_valid = 1; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        chk({tag, "_lat1"}, ov32, 0);
        @(negedge clk);
        chk({tag, "_ov"}, ov32, 1);
        chk({tag, "_r32"}, {c32, v32}, e32);
        chk({tag, "_r16"}, {c16, v16}, e16);
    endtask

    function automatic logic [7:0] pick_rs();
        int s;
        s = int'($urandom_range(0, 15));
        if (s < 12) return rs_tbl[s];
        return 8'($urandom);
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got [3];
        int n, cnt;
        bit cacc;
        rst = 1; flush = 0; in_valid = 0; out_ready = 0;
        imm = 0; mem = 0; cin = 0; rm = 0; rs = 0; so = 0;
        repeat (3) @(posedge clk);
        mon_en = 1;
        @(negedge clk);
        chk("rst_ov", ov32, 0);
        chk("rst_val", {c32, v32}, 0);
        chk("rst_val16", {ov16, c16, v16}, 0);
        chk("rst_rdy", rdy32, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_rdy1", rdy32, 1);

        run_one("imm4ff", 1, 0, 12'h4FF, 64'h0, 8'd0, 0,
                64'h1_FF00_0000, 64'h1_FF00);
        run_one("lsr0", 0, 0, 12'h020, 64'h8000_0001, 8'd0, 0,
                64'h1_0000_0000, 64'h0);
        run_one("rrx", 0, 0, 12'h060, 64'h3, 8'd0, 1,
                64'h1_8000_0001, 64'h1_8001);
        run_one("lsl32", 0, 0, 12'h010, 64'h1, 8'd32, 0,
                64'h1_0000_0000, 64'h0);
        run_one("lsl33", 0, 0, 12'h010, 64'h1, 8'd33, 0,
                64'h0, 64'h0);
        run_one("lsl0", 0, 0, 12'h010, 64'h1, 8'd0, 1,
                64'h1_0000_0001, 64'h1_0001);
        run_one("mem800", 0, 1, 12'h800, 64'h0, 8'd0, 0,
                64'h800, 64'hF800);
        run_one("imm8ab", 1, 0, 12'h8AB, 64'h0, 8'd0, 0,
                64'h00AB_0000, 64'hAB);
        run_one("asr40", 0, 0, 12'h050, 64'h8000_0000, 8'd40, 0,
                64'h1_FFFF_FFFF, 64'h0);
        run_one("ror32", 0, 0, 12'h070, 64'h8000_0001, 8'd32, 0,
                64'h1_8000_0001, 64'h1);
        run_one("lsl4i", 0, 0, 12'h200, 64'h1000_000F, 8'd0, 0,
                64'h1_0000_00F0, 64'hF0);

        // back-pressure: three back-to-back with out_ready low
        @(posedge clk); #1;
        out_ready = 0; in_valid = 1; imm = 1; mem = 0; so = 12'h4FF;
        cin = 0; rm = 0; rs = 0;
        @(posedge clk); #1;
        imm = 0; mem = 1; so = 12'h123;
        @(posedge clk); #1;
        mem = 0; so = 12'h010; rm = 64'hF; rs = 8'd4;
        @(negedge clk);
        chk("bp_rdy", rdy32, 0);
        chk("bp_ov", ov32, 1);
        chk("bp_hold0", {c32, v32}, 64'h1_FF00_0000);
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold", {ov32, c32, v32}, 64'h3_FF00_0000);
        end
        @(posedge clk); #1;
        out_ready = 1;
        n = 0;
        cacc = 0;
        for (int i = 0; i < 12 && n < 3; i++) begin
            @(negedge clk);
            if (ov32) begin
                got[n] = {c32, v32};
                n++;
            end
            if (in_valid && rdy32) cacc = 1;
            @(posedge clk); #1;
            if (cacc) in_valid = 0;
        end
        in_valid = 0;
        chk("bp_n", n, 3);
        chk("bp_r0", got[0], 64'h1_FF00_0000);
        chk("bp_r1", got[1], 64'h123);
        chk("bp_r2", got[2], 64'hF0);

        // flush with both stages full and a new transfer offered
        @(posedge clk); #1;
        out_ready = 0; in_valid = 1; mem = 1; imm = 0; so = 12'h111;
        @(posedge clk); #1;
        so = 12'h222;
        @(posedge clk); #1;
        so = 12'h333; flush = 1;
        @(negedge clk);
        chk("fl_rdy", rdy32, 0);
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        @(negedge clk);
        chk("fl_ov", ov32, 0);
        @(posedge clk); #1;
        out_ready = 1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (ov32 || ov16) cnt++;
        end
        chk("fl_none", cnt, 0);

        // reset with an operation in flight
        @(posedge clk); #1;
        in_valid = 1; out_ready = 0; mem = 1; so = 12'h005;
        @(posedge clk); #1;
        in_valid = 0; rst = 1;
        @(negedge clk);
        chk("mr_rdy", rdy32, 0);
        @(posedge clk); #1;
        rst = 0; out_ready = 1;
        @(negedge clk);
        chk("mr_rdy1", rdy32, 1);
        chk("mr_ov", ov32, 0);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (ov32) cnt++;
        end
        chk("mr_none", cnt, 0);

        // random traffic against the reference model
        for (int k = 0; k < 1500; k++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 59) == 0);
            rst       = ($urandom_range(0, 149) == 0);
            rm  = {$urandom, $urandom};
            so  = 12'($urandom);
            if ($urandom_range(0, 3) == 0) so[11:7] = 5'd0;
            imm = ($urandom_range(0, 3) == 0);
            mem = ($urandom_range(0, 4) == 0);
            cin = 1'($urandom_range(0, 1));
            rs  = pick_rs();
        end
        @(posedge clk); #1;
        flush = 0; rst = 0; in_valid = 0; out_ready = 1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("drain32", 64'(q32.size()), 0);
        chk("drain16", 64'(q16.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
